// File: rtl/lr_arbiter.sv
// Local-RAM arbiter: round-robin access for two masters, read-data return
// routing, and a zero-fill engine that sweeps every RAM word.
module lr_arbiter #(
   parameter int          AW   = 12,
   parameter logic [31:0] FILL = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic [3:0]    m0_we,
   input  logic [31:0]   m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic [3:0]    m1_we,
   input  logic [31:0]   m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   input  logic          clr_start,
   output logic          clr_busy,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_din,
   output logic [3:0]    ram_we,
   output logic          ram_en,
   input  logic [31:0]   ram_dout
);

   // Handshake: a master holds req/addr/we/wdata until gnt is seen high in a
   // cycle; that cycle is the RAM access, and read data follows one cycle later.

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;   // 1: m1 was granted most recently
   logic          rd0_q, rd0_d;
   logic          rd1_q, rd1_d;
   logic          arb_ok;
   logic          gnt0, gnt1;

   // Arbitration only runs in IDLE and yields to a clear command.
   always_comb begin
      arb_ok = !reset && (state_q == ST_IDLE) && !clr_start;
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      if (arb_ok) begin
         if (m0_req && m1_req) begin
            if (last_q) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
         end else if (m0_req) begin
            gnt0 = 1'b1;
         end else if (m1_req) begin
            gnt1 = 1'b1;
         end
      end
   end

   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 4'h0;
      ram_addr = '0;
      ram_din  = 32'h0;
      if (!reset) begin
         if (state_q == ST_CLEAR) begin
            ram_en   = 1'b1;
            ram_we   = 4'hF;
            ram_addr = cnt_q;
            ram_din  = FILL;
         end else if (gnt0) begin
            ram_en   = 1'b1;
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
         end else if (gnt1) begin
            ram_en   = 1'b1;
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      rd0_d   = gnt0 && (m0_we == 4'h0);
      rd1_d   = gnt1 && (m1_we == 4'h0);
      if (gnt0) last_d = 1'b0;
      if (gnt1) last_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            // Counter wraps to 0 on the last word, ready for the next sweep.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         rd0_q   <= 1'b0;
         rd1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign m0_rvalid = rd0_q;
   assign m1_rvalid = rd1_q;
   assign m0_rdata  = ram_dout;
   assign m1_rdata  = ram_dout;
   assign clr_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_lr_arbiter.sv
// Directed bench for lr_arbiter: behavioural RAM, reference memory model and
// per-master expected read-data queues.
module tb_lr_arbiter;

   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_req, m1_req;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [3:0]    m0_we, m1_we;
   logic [31:0]   m0_wdata, m1_wdata;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0]   m0_rdata, m1_rdata;
   logic          clr_start, clr_busy;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din, ram_dout;
   logic [3:0]    ram_we;
   logic          ram_en;

   logic [31:0] ram_mem [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] exp0_q[$];
   logic [31:0] exp1_q[$];
   logic        cur_rv0, cur_rv1;
   int          tests = 0;
   int          fails = 0;

   lr_arbiter #(.AW(AW), .FILL(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .clr_start(clr_start), .clr_busy(clr_busy),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // 1-cycle synchronous RAM with byte enables.
   always @(posedge clk) begin
      if (ram_en === 1'b1) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
         ram_dout <= ram_mem[ram_addr];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_m0(input logic r, input logic [AW-1:0] a, input logic [3:0] w,
                         input logic [31:0] d);
      m0_req = r; m0_addr = a; m0_we = w; m0_wdata = d;
   endtask

   task automatic set_m1(input logic r, input logic [AW-1:0] a, input logic [3:0] w,
                         input logic [31:0] d);
      m1_req = r; m1_addr = a; m1_we = w; m1_wdata = d;
   endtask

   // Called at posedge+1 with inputs set; checks this cycle and advances one cycle.
   task automatic step(input string tag, input logic eg0, input logic eg1);
      logic        nxt0, nxt1;
      logic [31:0] e;
      #4;
      chk({tag, ":m0_gnt"}, {31'b0, m0_gnt}, {31'b0, eg0});
      chk({tag, ":m1_gnt"}, {31'b0, m1_gnt}, {31'b0, eg1});
      chk({tag, ":m0_rvalid"}, {31'b0, m0_rvalid}, {31'b0, cur_rv0});
      chk({tag, ":m1_rvalid"}, {31'b0, m1_rvalid}, {31'b0, cur_rv1});
      if (cur_rv0) begin
         e = (exp0_q.size() > 0) ? exp0_q.pop_front() : 32'hxxxx_xxxx;
         chk({tag, ":m0_rdata"}, m0_rdata, e);
      end
      if (cur_rv1) begin
         e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 32'hxxxx_xxxx;
         chk({tag, ":m1_rdata"}, m1_rdata, e);
      end
      nxt0 = 1'b0;
      nxt1 = 1'b0;
      if (eg0) begin
         if (m0_we == 4'h0) begin exp0_q.push_back(ref_mem[m0_addr]); nxt0 = 1'b1; end
         else ref_mem[m0_addr] = merge(ref_mem[m0_addr], m0_wdata, m0_we);
      end
      if (eg1) begin
         if (m1_we == 4'h0) begin exp1_q.push_back(ref_mem[m1_addr]); nxt1 = 1'b1; end
         else ref_mem[m1_addr] = merge(ref_mem[m1_addr], m1_wdata, m1_we);
      end
      cur_rv0 = nxt0;
      cur_rv1 = nxt1;
      @(posedge clk); #1;
   endtask

   // Counts cycles with clr_busy high (from now) and any grant during them.
   task automatic clear_wait(output int busy, output int gnts);
      busy = 0;
      gnts = 0;
      while (busy < 5000) begin
         if (clr_busy !== 1'b1) break;
         busy++;
         if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) gnts++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int          busy, gnts;
      logic [AW-1:0] a;
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = i * 32'h9E37_79B1;
         ref_mem[i] = i * 32'h9E37_79B1;
      end
      cur_rv0 = 1'b0;
      cur_rv1 = 1'b0;
      set_m0(0, '0, 4'h0, 32'h0);
      set_m1(0, '0, 4'h0, 32'h0);
      clr_start = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst:clr_busy", {31'b0, clr_busy}, 32'h0);
      chk("rst:ram_en", {31'b0, ram_en}, 32'h0);
      chk("rst:ram_we", {28'b0, ram_we}, 32'h0);
      step("rst", 0, 0);

      // Round-robin: m0 wins the first tie after reset.
      set_m0(1, 12'h020, 4'h0, 32'h0);
      set_m1(1, 12'h030, 4'h0, 32'h0);
      for (int i = 0; i < 6; i++) step("rr", (i % 2) == 0, (i % 2) == 1);
      set_m0(0, '0, 4'h0, 32'h0);
      set_m1(0, '0, 4'h0, 32'h0);
      step("rr_tail", 0, 0);

      set_m0(1, 12'h010, 4'hF, 32'hDEAD_BEEF);
      step("m0_wr", 1, 0);
      set_m0(1, 12'h010, 4'h0, 32'h0);
      step("m0_rd", 1, 0);
      set_m0(0, '0, 4'h0, 32'h0);
      step("m0_rd_tail", 0, 0);

      set_m1(1, 12'h010, 4'b0100, 32'h00AB_0000);
      step("m1_bwr", 0, 1);
      set_m1(1, 12'h010, 4'h0, 32'h0);
      step("m1_rd", 0, 1);
      set_m1(0, '0, 4'h0, 32'h0);
      step("m1_rd_tail", 0, 0);

      for (int i = 0; i < 4; i++) begin
         a = AW'($urandom_range(0, DEPTH - 1));
         set_m0(1, a, 4'h0, 32'h0);
         step("b2b", 1, 0);
      end
      set_m0(0, '0, 4'h0, 32'h0);
      step("b2b_tail", 0, 0);

      // Clear with m1 waiting: clr_start wins the tie with the request.
      set_m1(1, 12'h010, 4'h0, 32'h0);
      clr_start = 1'b1;
      step("clr_start", 0, 0);
      clr_start = 1'b0;
      clear_wait(busy, gnts);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      chk("clr:busy_cycles", busy, 32'd4096);
      chk("clr:gnt_during", gnts, 32'd0);
      step("clr_done", 0, 1);
      a = AW'($urandom_range(0, DEPTH - 1));
      set_m1(1, a, 4'h0, 32'h0);
      step("clr_rd1", 0, 1);
      set_m1(0, '0, 4'h0, 32'h0);
      a = AW'($urandom_range(0, DEPTH - 1));
      set_m0(1, a, 4'h0, 32'h0);
      step("clr_rd0", 1, 0);
      set_m0(0, '0, 4'h0, 32'h0);
      step("clr_rd_tail", 0, 0);

      // Reset during the sweep, then a fresh sweep from address 0.
      clr_start = 1'b1;
      step("clr2_start", 0, 0);
      clr_start = 1'b0;
      repeat (100) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort:clr_busy", {31'b0, clr_busy}, 32'h0);
      chk("abort:ram_we", {28'b0, ram_we}, 32'h0);
      chk("abort:ram_en", {31'b0, ram_en}, 32'h0);
      clr_start = 1'b1;
      step("clr3_start", 0, 0);
      clr_start = 1'b0;
      chk("clr3:ram_addr", {20'b0, ram_addr}, 32'h0);
      chk("clr3:ram_we", {28'b0, ram_we}, 32'hF);
      chk("clr3:ram_din", ram_din, 32'h0);
      chk("clr3:ram_en", {31'b0, ram_en}, 32'h1);
      clear_wait(busy, gnts);
      chk("clr3:busy_cycles", busy, 32'd4096);
      a = AW'($urandom_range(0, DEPTH - 1));
      set_m0(1, a, 4'h0, 32'h0);
      step("clr3_rd", 1, 0);
      set_m0(0, '0, 4'h0, 32'h0);
      step("clr3_rd_tail", 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
